// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and default widths for the convolution address generator.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int C_ADDR_W = 20;
    localparam int C_LEN_W  = 11;
    localparam int C_NUM_PE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    // The IFM base is absorbed into the running pixel-base register, so it is not kept here.
    typedef struct packed {
        logic [C_LEN_W-1:0]  win_len;
        logic [C_LEN_W-1:0]  num_pix;
        logic [C_ADDR_W-1:0] ifm_stride;
        logic [C_ADDR_W-1:0] w_base;
        logic [C_NUM_PE-1:0] pe_mask;
    } conv_cfg_t;

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_addr_gen_if
// Brief    : Config, stall and BRAM-address/strobe bundle of the address generator.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_addr_gen_if #(
    parameter int ADDR_W = 20,
    parameter int LEN_W  = 11,
    parameter int NUM_PE = 16
) ();

    logic              start;
    logic [LEN_W-1:0]  cfg_win_len;
    logic [LEN_W-1:0]  cfg_num_pix;
    logic [ADDR_W-1:0] cfg_ifm_base;
    logic [ADDR_W-1:0] cfg_ifm_stride;
    logic [ADDR_W-1:0] cfg_w_base;
    logic [NUM_PE-1:0] cfg_pe_mask;
    logic              hold;
    logic [ADDR_W-1:0] ifm_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [NUM_PE-1:0] PE_en;
    logic [NUM_PE-1:0] PE_finish;
    logic              busy;
    logic              done;

    modport master (
        output start, cfg_win_len, cfg_num_pix, cfg_ifm_base, cfg_ifm_stride,
               cfg_w_base, cfg_pe_mask, hold,
        input  ifm_addr, w_addr, PE_en, PE_finish, busy, done
    );

    modport slave (
        input  start, cfg_win_len, cfg_num_pix, cfg_ifm_base, cfg_ifm_stride,
               cfg_w_base, cfg_pe_mask, hold,
        output ifm_addr, w_addr, PE_en, PE_finish, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/conv_addr_gen_win_counter.sv
`default_nettype none
// ============================================================================
// Module   : win_counter
// Brief    : Nested word (k) / pixel (p) counter with advance enable.
// Revision : 1.0 - initial release
// ============================================================================
module win_counter #(
    parameter int LEN_W = 11
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_clr,
    input  wire logic             i_adv,
    input  wire logic [LEN_W-1:0] i_win_len,
    input  wire logic [LEN_W-1:0] i_num_pix,
    output logic      [LEN_W-1:0] o_k,
    output logic                  o_last_word,
    output logic                  o_last_pix
);

    localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

    logic [LEN_W-1:0] r_k;
    logic [LEN_W-1:0] r_p;
    logic             w_last_word;
    logic             w_last_pix;

    assign w_last_word = (r_k == (i_win_len - c_one));
    assign w_last_pix  = (r_p == (i_num_pix - c_one));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k <= '0;
            r_p <= '0;
        end else if (i_clr) begin
            r_k <= '0;
            r_p <= '0;
        end else if (i_adv) begin
            if (w_last_word) begin
                r_k <= '0;
                r_p <= w_last_pix ? '0 : (r_p + c_one);
            end else begin
                r_k <= r_k + c_one;
            end
        end
    end

    assign o_k         = r_k;
    assign o_last_word = w_last_word;
    assign o_last_pix  = w_last_pix;

endmodule
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_addr_gen
// Brief    : Walks P pixel windows of L words, driving BRAM addresses and PE strobes.
// Revision : 1.0 - initial release
// ============================================================================
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int LEN_W  = C_LEN_W,
    parameter int NUM_PE = C_NUM_PE
) (
    input  wire logic  clk,
    input  wire logic  reset,
    conv_addr_gen_if.slave bus
);

    conv_state_e       r_state;
    conv_cfg_t         r_cfg;
    logic [ADDR_W-1:0] r_pix_base;
    logic [NUM_PE-1:0] r_pe_en;
    logic [NUM_PE-1:0] r_pe_finish;
    logic              r_busy;
    logic              r_done;

    logic [LEN_W-1:0]  w_k;
    logic [ADDR_W-1:0] w_k_ext;
    logic              w_last_word;
    logic              w_last_pix;
    logic              w_issue_v;
    logic              w_accept;
    logic              w_zero_cfg;

    assign w_issue_v  = (r_state == RUN) && !bus.hold;
    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_zero_cfg = (bus.cfg_win_len == '0) || (bus.cfg_num_pix == '0);

    win_counter #(
        .LEN_W (LEN_W)
    ) u_win_counter (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_accept),
        .i_adv       (w_issue_v),
        .i_win_len   (r_cfg.win_len),
        .i_num_pix   (r_cfg.num_pix),
        .o_k         (w_k),
        .o_last_word (w_last_word),
        .o_last_pix  (w_last_pix)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cfg       <= '0;
            r_pix_base  <= '0;
            r_pe_en     <= '0;
            r_pe_finish <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Strobes trail the address by one cycle to line up with BRAM read data.
            r_pe_en     <= w_issue_v ? r_cfg.pe_mask : '0;
            r_pe_finish <= (w_issue_v && w_last_word) ? r_cfg.pe_mask : '0;

            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_cfg.win_len    <= bus.cfg_win_len;
                        r_cfg.num_pix    <= bus.cfg_num_pix;
                        r_cfg.ifm_stride <= bus.cfg_ifm_stride;
                        r_cfg.w_base     <= bus.cfg_w_base;
                        r_cfg.pe_mask    <= bus.cfg_pe_mask;
                        r_pix_base       <= bus.cfg_ifm_base;
                        if (w_zero_cfg) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_issue_v && w_last_word) begin
                        r_pix_base <= r_pix_base + r_cfg.ifm_stride;
                        if (w_last_pix) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign w_k_ext       = ADDR_W'(w_k);
    assign bus.ifm_addr  = r_pix_base + w_k_ext;
    assign bus.w_addr    = r_cfg.w_base + w_k_ext;
    assign bus.PE_en     = r_pe_en;
    assign bus.PE_finish = r_pe_finish;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire
